// File: rtl/fetch_unit_if.sv
//==============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory request/response channel plus the
//               downstream instruction channel of the fetch front end.
//               master = fetch unit side, slave = memory/consumer side.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fetch_unit_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [29:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [29:0] out_pc;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      output out_valid,
      output out_instr,
      output out_pc,
      input  out_ready
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      input  out_valid,
      input  out_instr,
      input  out_pc,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
//==============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Holds the word PC, issues in-order
//               imem requests under a credit rule, buffers returned words in a
//               small FIFO and flushes all in-flight work on a redirect.
//               Optional macro FETCH_PERF_EN adds perf_fetched, perf_dropped
//               and perf_redirects counters.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_unit #(
   parameter logic [29:0] RESET_PC        = 30'h0,
   parameter int          FIFO_DEPTH      = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        jmp_enable,
   input  wire logic [29:0] jmp_addr,
   fetch_unit_if.master     bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_dropped,
   output logic [31:0]      perf_redirects
`endif
);

   localparam int c_FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CW  = $clog2(FIFO_DEPTH + 1);
   localparam int c_OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int c_AQW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   // registered state
   logic [29:0]      pc_q, pc_d;
   logic [c_OW-1:0]  inflight_q, inflight_d;
   logic [c_OW-1:0]  drop_q, drop_d;
   logic [c_FPW-1:0] fifo_wr_q, fifo_wr_d;
   logic [c_FPW-1:0] fifo_rd_q, fifo_rd_d;
   logic [c_CW-1:0]  count_q, count_d;
   logic [c_AQW-1:0] aq_wr_q, aq_wr_d;
   logic [c_AQW-1:0] aq_rd_q, aq_rd_d;
   logic [31:0]      fifo_instr_q [FIFO_DEPTH];
   logic [29:0]      fifo_pc_q    [FIFO_DEPTH];
   logic [29:0]      aq_q         [MAX_OUTSTANDING];

   // combinational handshakes
   logic             w_out_valid;
   logic             w_pop;
   logic             w_credit;
   logic             w_req_valid;
   logic             w_accept;
   logic             w_rsp;
   logic             w_dropping;
   logic             w_push;
   logic [c_OW-1:0]  w_kept;

   function automatic logic [c_AQW-1:0] aq_next(input logic [c_AQW-1:0] p);
      if (p == c_AQW'(MAX_OUTSTANDING - 1)) return '0;
      return p + c_AQW'(1);
   endfunction

   // Output side depends on registered occupancy only (plus reset gating).
   assign w_out_valid = !rst && (count_q != '0);
   assign w_pop       = w_out_valid && bus.out_ready;

   // A slot freed by this cycle's pop is counted as free, which is what lets a
   // depth-2 buffer sustain one instruction per cycle with a 1-cycle memory.
   assign w_kept      = inflight_q - drop_q;
   assign w_credit    = (32'(w_kept) + 32'(count_q) - 32'(w_pop)) < 32'(FIFO_DEPTH);
   assign w_req_valid = !rst && !jmp_enable &&
                        (32'(inflight_q) < 32'(MAX_OUTSTANDING)) && w_credit;
   assign w_accept    = w_req_valid && bus.imem_req_ready;
   assign w_rsp       = bus.imem_rsp_valid;
   assign w_dropping  = w_rsp && (drop_q != '0);
   assign w_push      = w_rsp && (drop_q == '0) && !jmp_enable;

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.out_valid      = w_out_valid;
   assign bus.out_instr      = fifo_instr_q[fifo_rd_q];
   assign bus.out_pc         = fifo_pc_q[fifo_rd_q];

   // Next-state: PC advance, outstanding/drop accounting, FIFO and address queue pointers.
   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      fifo_wr_d  = fifo_wr_q;
      fifo_rd_d  = fifo_rd_q;
      count_d    = count_q;
      aq_wr_d    = aq_wr_q;
      aq_rd_d    = aq_rd_q;

      if (w_accept && !w_rsp)      inflight_d = inflight_q + c_OW'(1);
      else if (!w_accept && w_rsp) inflight_d = inflight_q - c_OW'(1);

      if (w_accept) begin
         pc_d    = pc_q + 30'd1;
         aq_wr_d = aq_next(aq_wr_q);
      end
      if (w_push) begin
         fifo_wr_d = fifo_wr_q + c_FPW'(1);
         aq_rd_d   = aq_next(aq_rd_q);
      end
      if (w_pop) fifo_rd_d = fifo_rd_q + c_FPW'(1);

      if (w_push && !w_pop)      count_d = count_q + c_CW'(1);
      else if (!w_push && w_pop) count_d = count_q - c_CW'(1);

      if (w_dropping) drop_d = drop_q - c_OW'(1);

      // Redirect wins: everything still outstanding after this cycle's
      // response accounting becomes a drop.
      if (jmp_enable) begin
         pc_d      = jmp_addr;
         fifo_wr_d = '0;
         fifo_rd_d = '0;
         count_d   = '0;
         aq_wr_d   = '0;
         aq_rd_d   = '0;
         drop_d    = inflight_d;
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
         fifo_wr_q  <= '0;
         fifo_rd_q  <= '0;
         count_q    <= '0;
         aq_wr_q    <= '0;
         aq_rd_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         fifo_wr_q  <= fifo_wr_d;
         fifo_rd_q  <= fifo_rd_d;
         count_q    <= count_d;
         aq_wr_q    <= aq_wr_d;
         aq_rd_q    <= aq_rd_d;
      end
   end

   // Data storage: requested addresses and returned {instr, pc} entries.
   always_ff @(posedge clk) begin
      if (w_accept) aq_q[aq_wr_q] <= pc_q;
      if (w_push) begin
         fifo_instr_q[fifo_wr_q] <= bus.imem_rsp_data;
         fifo_pc_q[fifo_wr_q]    <= aq_q[aq_rd_q];
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_dropped_q, perf_redirects_q;

   // Event counters: buffered words, discarded responses, redirect cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q   <= '0;
         perf_dropped_q   <= '0;
         perf_redirects_q <= '0;
      end else begin
         if (w_push)                                      perf_fetched_q   <= perf_fetched_q + 32'd1;
         if (w_rsp && ((drop_q != '0) || jmp_enable))     perf_dropped_q   <= perf_dropped_q + 32'd1;
         if (jmp_enable)                                  perf_redirects_q <= perf_redirects_q + 32'd1;
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_dropped   = perf_dropped_q;
   assign perf_redirects = perf_redirects_q;
`endif

endmodule

`default_nettype wire
